// File: rtl/fetch_pkg.sv
// Shared types and default widths/entry points for the instruction-fetch stage.
// The defaults must stay in step with the instruction ROM geometry.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } fetch_state_t;

    localparam int IW = 16;
    localparam int CW = 16;
    localparam int OW = 8;

    localparam logic [IW-1:0] PROG0_BASE_DEFAULT = 16'h0000;
    localparam logic [IW-1:0] PROG1_BASE_DEFAULT = 16'h0040;
    localparam logic [IW-1:0] PROG2_BASE_DEFAULT = 16'h0080;
    localparam logic [IW-1:0] PROG3_BASE_DEFAULT = 16'h00C0;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection while a program is running.
// Priority: halt (hold) > jump (absolute) > branch (PC-relative) > sequential.
module pc_next
    import fetch_pkg::*;
#(
    parameter int IW = fetch_pkg::IW,
    parameter int OW = fetch_pkg::OW
) (
    input  logic [IW-1:0] pc,
    input  logic          halt,
    input  logic          jump,
    input  logic [IW-1:0] jump_target,
    input  logic          branch,
    input  logic [OW-1:0] br_offset,
    output logic [IW-1:0] pc_nxt
);

    logic [IW-1:0] br_offset_sext;

    assign br_offset_sext = {{(IW-OW){br_offset[OW-1]}}, br_offset};

    // Carries out of the top bit are dropped, so both adds wrap modulo 2**IW.
    always_comb begin
        pc_nxt = pc + IW'(1);
        if (halt) begin
            pc_nxt = pc;
        end else if (jump) begin
            pc_nxt = jump_target;
        end else if (branch) begin
            pc_nxt = pc + br_offset_sext;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Program counter and fetch sequencing: entry-point start, redirects, halt,
// and a saturating count of cycles spent in RUN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int            IW         = fetch_pkg::IW,
    parameter int            CW         = fetch_pkg::CW,
    parameter int            OW         = fetch_pkg::OW,
    parameter logic [IW-1:0] PROG0_BASE = PROG0_BASE_DEFAULT,
    parameter logic [IW-1:0] PROG1_BASE = PROG1_BASE_DEFAULT,
    parameter logic [IW-1:0] PROG2_BASE = PROG2_BASE_DEFAULT,
    parameter logic [IW-1:0] PROG3_BASE = PROG3_BASE_DEFAULT
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          Start,
    input  logic [1:0]    ProgSel,
    input  logic          Branch,
    input  logic [OW-1:0] BrOffset,
    input  logic          Jump,
    input  logic [IW-1:0] JumpTarget,
    input  logic          Halt,
    output logic [IW-1:0] InstAddress,
    output logic          Fetching,
    output logic          Done,
    output logic [CW-1:0] CycleCount
);

    // state  | meaning
    // IDLE   | after reset, waiting for Start; PC holds
    // RUN    | fetching; PC advances or redirects every edge, cycles counted
    // HALTED | program stopped; PC and count frozen, Done high, Start restarts

    fetch_state_t  state_q, state_d;
    logic [IW-1:0] pc_q, pc_d;
    logic [CW-1:0] cc_q, cc_d;
    logic [IW-1:0] run_pc_nxt;
    logic [IW-1:0] entry_base;

    pc_next #(
        .IW(IW),
        .OW(OW)
    ) u_pc_next (
        .pc         (pc_q),
        .halt       (Halt),
        .jump       (Jump),
        .jump_target(JumpTarget),
        .branch     (Branch),
        .br_offset  (BrOffset),
        .pc_nxt     (run_pc_nxt)
    );

    always_comb begin
        case (ProgSel)
            2'd0:    entry_base = PROG0_BASE;
            2'd1:    entry_base = PROG1_BASE;
            2'd2:    entry_base = PROG2_BASE;
            default: entry_base = PROG3_BASE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cc_q    <= cc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cc_d    = cc_q;
        case (state_q)
            IDLE, HALTED: begin
                if (Start) begin
                    pc_d    = entry_base;
                    cc_d    = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // The halting edge is still a RUN cycle and is counted.
                cc_d = (&cc_q) ? cc_q : cc_q + CW'(1);
                pc_d = run_pc_nxt;
                if (Halt) begin
                    state_d = HALTED;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign InstAddress = pc_q;
    assign CycleCount  = cc_q;
    assign Fetching    = (state_q == RUN);
    assign Done        = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: a driver predicts each edge's outputs from
// an abstract model and queues them; a monitor compares after every rising edge.
module tb_fetch_unit;

    logic        CLK;
    logic        Reset;
    logic        Start;
    logic [1:0]  ProgSel;
    logic        Branch;
    logic [7:0]  BrOffset;
    logic        Jump;
    logic [15:0] JumpTarget;
    logic        Halt;
    logic [15:0] InstAddress;
    logic        Fetching;
    logic        Done;
    logic [15:0] CycleCount;

    fetch_unit dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Start      (Start),
        .ProgSel    (ProgSel),
        .Branch     (Branch),
        .BrOffset   (BrOffset),
        .Jump       (Jump),
        .JumpTarget (JumpTarget),
        .Halt       (Halt),
        .InstAddress(InstAddress),
        .Fetching   (Fetching),
        .Done       (Done),
        .CycleCount (CycleCount)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        int unsigned pc;
        bit          fetching;
        bit          done;
        int unsigned cc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests;
    int   n_fail;

    // Reference model: mode 0 = idle, 1 = running, 2 = halted.
    int          m_mode;
    int unsigned m_pc;
    int unsigned m_cc;
    int unsigned bases[4] = '{32'h0000, 32'h0040, 32'h0080, 32'h00C0};

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    function automatic void model_step(input bit rst, input bit st, input int sel,
                                       input bit br, input int off, input bit jmp,
                                       input int unsigned tgt, input bit hlt);
        int disp;
        if (rst) begin
            m_mode = 0;
            m_pc   = 0;
            m_cc   = 0;
        end else if (m_mode == 1) begin
            if (m_cc < 65535) m_cc = m_cc + 1;
            disp = (off >= 128) ? off - 256 : off;
            if (hlt)      m_mode = 2;
            else if (jmp) m_pc = tgt;
            else if (br)  m_pc = (m_pc + 65536 + disp) % 65536;
            else          m_pc = (m_pc + 1) % 65536;
        end else if (st) begin
            m_pc   = bases[sel];
            m_cc   = 0;
            m_mode = 1;
        end
    endfunction

    function automatic exp_t model_outputs();
        exp_t e;
        e.pc       = m_pc;
        e.fetching = (m_mode == 1);
        e.done     = (m_mode == 2);
        e.cc       = m_cc;
        return e;
    endfunction

    // Drive one cycle's inputs (just after an edge), predict, then advance to edge+2.
    task automatic cycle(input bit rst, input bit st, input logic [1:0] sel, input bit br,
                         input logic [7:0] off, input bit jmp, input logic [15:0] tgt,
                         input bit hlt);
        Reset      = rst;
        Start      = st;
        ProgSel    = sel;
        Branch     = br;
        BrOffset   = off;
        Jump       = jmp;
        JumpTarget = tgt;
        Halt       = hlt;
        model_step(rst, st, int'(sel), br, int'(off), jmp, int'(tgt), hlt);
        exp_q.push_back(model_outputs());
        @(posedge CLK);
        #2;
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
    endtask

    always @(posedge CLK) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("mon_inst_address", InstAddress, e.pc);
            chk("mon_fetching", Fetching, e.fetching);
            chk("mon_done", Done, e.done);
            chk("mon_cycle_count", CycleCount, e.cc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] held_pc;
        n_tests = 0;
        n_fail  = 0;
        m_mode  = 0;
        m_pc    = 0;
        m_cc    = 0;

        cycle(1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        chk("reset_addr", InstAddress, 0);
        chk("reset_fetching", Fetching, 0);
        idle_cycle();

        // Entry point 1, then three sequential fetches
        cycle(1'b0, 1'b1, 2'd1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        chk("start1_addr", InstAddress, 16'h0040);
        chk("start1_fetching", Fetching, 1);
        repeat (3) idle_cycle();
        chk("start1_seq_addr", InstAddress, 16'h0043);
        chk("start1_seq_cc", CycleCount, 3);

        // Branches backward and with wrap
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 16'h0010, 1'b0);
        cycle(1'b0, 1'b0, 2'd0, 1'b1, 8'hFC, 1'b0, 16'h0000, 1'b0);
        chk("branch_back", InstAddress, 16'h000C);
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 16'hFFF0, 1'b0);
        cycle(1'b0, 1'b0, 2'd0, 1'b1, 8'h7F, 1'b0, 16'h0000, 1'b0);
        chk("branch_wrap", InstAddress, 16'h006F);

        // Priority: jump over branch, halt over jump
        cycle(1'b0, 1'b0, 2'd0, 1'b1, 8'h10, 1'b1, 16'h0100, 1'b0);
        chk("jump_over_branch", InstAddress, 16'h0100);
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 16'h2000, 1'b1);
        chk("halt_over_jump_addr", InstAddress, 16'h0100);
        chk("halt_over_jump_done", Done, 1);

        // Restart from HALTED, ten RUN edges with halt on the tenth
        cycle(1'b0, 1'b1, 2'd0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        repeat (9) idle_cycle();
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1);
        chk("halt10_done", Done, 1);
        chk("halt10_cc", CycleCount, 10);
        held_pc = InstAddress;
        chk("halt10_addr", InstAddress, 16'h0009);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 2'd0, 1'b1, 8'h33, 1'b1, 16'h4444, 1'b1);
            chk("halted_pc_stable", InstAddress, held_pc);
        end
        cycle(1'b0, 1'b1, 2'd2, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        chk("restart2_done", Done, 0);
        chk("restart2_cc", CycleCount, 0);
        chk("restart2_addr", InstAddress, 16'h0080);

        // Sequential wrap at the top of the address space; Start ignored in RUN
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 16'hFFFF, 1'b0);
        idle_cycle();
        chk("seq_wrap", InstAddress, 16'h0000);
        cycle(1'b0, 1'b1, 2'd3, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        chk("start_in_run_ignored", InstAddress, 16'h0001);

        // Asynchronous reset mid-cycle while running at 0x0005
        cycle(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1, 16'h0005, 1'b0);
        chk("pre_reset_addr", InstAddress, 16'h0005);
        Reset = 1'b1;
        #1;
        chk("async_reset_addr", InstAddress, 0);
        chk("async_reset_fetching", Fetching, 0);
        chk("async_reset_done", Done, 0);
        chk("async_reset_cc", CycleCount, 0);
        #1;
        cycle(1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom % 200) == 0, ($urandom % 8) == 0, 2'($urandom % 4),
                  ($urandom % 4) == 0, 8'($urandom % 256), ($urandom % 6) == 0,
                  16'($urandom % 65536), ($urandom % 20) == 0);
        end

        idle_cycle();
        @(posedge CLK);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
